// File: rtl/sd_dev_data_tx_sequencer_if.sv
// Handshake and bus bundle for the SDIO 4-bit read-data transmitter.
//   i_stb         : one-clk SD-clock posedge strobe from the platform
//   i_start       : pulse, begin one block (size sampled with it)
//   i_abort       : pulse, terminate the current block at once
//   i_block_size  : bytes in the block
//   i_data        : payload byte, qualified by i_data_valid
//   o_data_ready  : byte accepted on a clk edge with valid && ready
//   o_sd_data_dir : 1 = device drives DAT[3:0]
//   o_sd_data_out : current nibble replicated as {nib,nib}
//   o_busy        : block in progress
//   o_done        : one-clk pulse after the end bit completes normally
//   o_underflow   : one-clk pulse per byte slot that found no byte buffered
// master = data source / controller side, slave = the sequencer.
interface sd_dev_data_tx_sequencer_if #(
  parameter int BLOCK_SIZE_W = 12
);
  logic                    i_stb;
  logic                    i_start;
  logic                    i_abort;
  logic [BLOCK_SIZE_W-1:0] i_block_size;
  logic [7:0]              i_data;
  logic                    i_data_valid;
  logic                    o_data_ready;
  logic                    o_sd_data_dir;
  logic [7:0]              o_sd_data_out;
  logic                    o_busy;
  logic                    o_done;
  logic                    o_underflow;

  modport master (
    output i_stb, i_start, i_abort, i_block_size, i_data, i_data_valid,
    input  o_data_ready, o_sd_data_dir, o_sd_data_out, o_busy, o_done, o_underflow
  );

  modport slave (
    input  i_stb, i_start, i_abort, i_block_size, i_data, i_data_valid,
    output o_data_ready, o_sd_data_dir, o_sd_data_out, o_busy, o_done, o_underflow
  );
endinterface

// File: rtl/sd_dev_data_tx_sequencer.sv
// Device-side SDIO read-data transmitter, 4-bit bus, SDR.
// Sequences one block per i_start: preamble (all ones), start bit, data nibbles
// (high nibble first), per-line CRC16 (MSB first) and end bit, advancing only on
// clk edges where bus.i_stb is high. A one-entry byte buffer prefetches payload.
// Ports:
//   clk : SD x2 clock, all logic on posedge
//   rst : synchronous active-high reset
//   bus : sd_dev_data_tx_sequencer_if.slave (handshake, PHY drive, status)
module sd_dev_data_tx_sequencer #(
  parameter int BLOCK_SIZE_W = 12,
  parameter int PREAMBLE_CYC = 1
) (
  input logic                       clk,
  input logic                       rst,
  sd_dev_data_tx_sequencer_if.slave bus
);
  localparam int PRE_W = (PREAMBLE_CYC > 1) ? $clog2(PREAMBLE_CYC) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_CYC - 1);
  localparam logic [BLOCK_SIZE_W-1:0] ONE = BLOCK_SIZE_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_START, S_DATA, S_CRC, S_END} state_t;

  state_t                  state_q, state_d;
  logic [BLOCK_SIZE_W-1:0] size_q, size_d;
  logic [BLOCK_SIZE_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [BLOCK_SIZE_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [PRE_W-1:0]        pre_cnt_q, pre_cnt_d;
  logic [3:0]              crc_cnt_q, crc_cnt_d;
  logic                    phase_q, phase_d;
  logic [7:0]              buf_q, buf_d;
  logic                    buf_full_q, buf_full_d;
  logic [7:0]              shift_q, shift_d;
  logic [3:0][15:0]        crc_q, crc_d, crc_upd;
  logic                    dir_q, dir_d;
  logic [7:0]              dout_q, dout_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    ufl_q, ufl_d;

  logic                    handshake;
  logic [7:0]              slot_byte;
  logic [3:0]              data_nib;
  logic [3:0]              crc_nib;

  assign bus.o_data_ready  = busy_q && !buf_full_q && (fetch_cnt_q < size_q);
  assign bus.o_sd_data_dir = dir_q;
  assign bus.o_sd_data_out = dout_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_done        = done_q;
  assign bus.o_underflow   = ufl_q;

  assign handshake = bus.o_data_ready && bus.i_data_valid;

  // Byte for a slot starting now. A byte arriving on the very edge that opens
  // an empty slot is forwarded straight through instead of reporting underflow.
  always_comb begin
    slot_byte = 8'hFF;
    if (buf_full_q) begin
      slot_byte = buf_q;
    end else if (handshake) begin
      slot_byte = bus.i_data;
    end
    data_nib = phase_q ? shift_q[3:0] : slot_byte[7:4];
  end

  // One CRC16 (0x1021, MSB first) per data line; crc_nib taps the MSBs,
  // which are shifted out during the CRC phase.
  for (genvar gi = 0; gi < 4; gi++) begin : g_line
    assign crc_upd[gi] = {crc_q[gi][14:0], 1'b0} ^
                         ((crc_q[gi][15] ^ data_nib[gi]) ? 16'h1021 : 16'h0000);
    assign crc_nib[gi] = crc_q[gi][15];
  end

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    byte_cnt_d  = byte_cnt_q;
    fetch_cnt_d = fetch_cnt_q;
    pre_cnt_d   = pre_cnt_q;
    crc_cnt_d   = crc_cnt_q;
    phase_d     = phase_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    shift_d     = shift_q;
    crc_d       = crc_q;
    dir_d       = dir_q;
    dout_d      = dout_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ufl_d       = 1'b0;

    if (state_q == S_IDLE) begin
      // Abort in the same cycle drops the start.
      if (bus.i_start && !bus.i_abort && (bus.i_block_size != '0)) begin
        size_d      = bus.i_block_size;
        byte_cnt_d  = '0;
        fetch_cnt_d = '0;
        pre_cnt_d   = '0;
        crc_cnt_d   = '0;
        phase_d     = 1'b0;
        buf_full_d  = 1'b0;
        crc_d       = '0;
        busy_d      = 1'b1;
        state_d     = S_PRE;
      end
    end else if (bus.i_abort) begin
      state_d    = S_IDLE;
      dir_d      = 1'b0;
      dout_d     = 8'hFF;
      busy_d     = 1'b0;
      buf_full_d = 1'b0;
      phase_d    = 1'b0;
    end else begin
      if (handshake) begin
        buf_d       = bus.i_data;
        buf_full_d  = 1'b1;
        fetch_cnt_d = fetch_cnt_q + ONE;
      end
      if (bus.i_stb) begin
        case (state_q)
          S_PRE: begin
            dir_d  = 1'b1;
            dout_d = 8'hFF;
            if (pre_cnt_q == PRE_LAST) begin
              state_d = S_START;
            end else begin
              pre_cnt_d = pre_cnt_q + 1'b1;
            end
          end
          S_START: begin
            dout_d  = 8'h00;
            state_d = S_DATA;
          end
          S_DATA: begin
            dout_d = {data_nib, data_nib};
            crc_d  = crc_upd;
            if (!phase_q) begin
              // Slot opens: the buffer is always drained (or bypassed) here.
              shift_d    = slot_byte;
              buf_full_d = 1'b0;
              phase_d    = 1'b1;
              if (!buf_full_q && !handshake) begin
                ufl_d       = 1'b1;
                fetch_cnt_d = fetch_cnt_q + ONE;
              end
            end else begin
              phase_d    = 1'b0;
              byte_cnt_d = byte_cnt_q + ONE;
              if (byte_cnt_q == size_q - ONE) begin
                state_d = S_CRC;
              end
            end
          end
          S_CRC: begin
            dout_d = {crc_nib, crc_nib};
            for (int k = 0; k < 4; k++) begin
              crc_d[k] = {crc_q[k][14:0], 1'b0};
            end
            crc_cnt_d = crc_cnt_q + 1'b1;
            if (crc_cnt_q == 4'd15) begin
              state_d = S_END;
            end
          end
          S_END: begin
            // phase_q marks that the end bit is already on the bus.
            dout_d = 8'hFF;
            if (!phase_q) begin
              phase_d = 1'b1;
            end else begin
              phase_d = 1'b0;
              dir_d   = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      size_q      <= '0;
      byte_cnt_q  <= '0;
      fetch_cnt_q <= '0;
      pre_cnt_q   <= '0;
      crc_cnt_q   <= '0;
      phase_q     <= 1'b0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      shift_q     <= '0;
      crc_q       <= '0;
      dir_q       <= 1'b0;
      dout_q      <= 8'hFF;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ufl_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      byte_cnt_q  <= byte_cnt_d;
      fetch_cnt_q <= fetch_cnt_d;
      pre_cnt_q   <= pre_cnt_d;
      crc_cnt_q   <= crc_cnt_d;
      phase_q     <= phase_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      shift_q     <= shift_d;
      crc_q       <= crc_d;
      dir_q       <= dir_d;
      dout_q      <= dout_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ufl_q       <= ufl_d;
    end
  end
endmodule

// File: tb/tb_sd_dev_data_tx_sequencer.sv
// Self-checking bench for sd_dev_data_tx_sequencer.
// Stimulus processes drive strobes, payload and control; a negedge monitor
// rebuilds the expected frame from accepted bytes (scoreboard queue) and a
// bit-serial polynomial-division CRC per line, and compares every strobe.
module tb_sd_dev_data_tx_sequencer;
  localparam int BW = 12;
  localparam int P  = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sd_dev_data_tx_sequencer_if #(.BLOCK_SIZE_W(BW)) ifc();

  sd_dev_data_tx_sequencer #(.BLOCK_SIZE_W(BW), .PREAMBLE_CYC(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // shared stimulus / model state
  int         stb_div   = 2;
  int         valid_pct = 100;
  bit         valid_en  = 1'b1;
  logic [7:0] src_q[$];
  bit         hs_flag;
  int         cur_n;
  int         mon_j;
  int         hs_cnt, ufl_cnt, done_cnt, drv_cnt;
  logic [7:0] exp_byte_q[$];
  logic [3:0] nib_hist[$];

  // Remainder of (line bits * x^16) mod (x^16+x^12+x^5+1).
  function automatic logic [15:0] crc_line(input int k);
    logic [16:0] rem;
    logic        b;
    rem = '0;
    for (int i = 0; i < nib_hist.size() + 16; i++) begin
      b = (i < nib_hist.size()) ? nib_hist[i][k] : 1'b0;
      rem = {rem[15:0], b};
      if (rem[16]) rem = rem ^ 17'h11021;
    end
    return rem[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // strobe generator
  initial begin
    int cnt;
    cnt = 0;
    ifc.i_stb = 1'b0;
    forever begin
      tick();
      cnt++;
      if (cnt >= stb_div) begin
        cnt = 0;
        ifc.i_stb = 1'b1;
      end else begin
        ifc.i_stb = 1'b0;
      end
    end
  end

  // payload source
  initial begin
    ifc.i_data_valid = 1'b0;
    ifc.i_data       = 8'h00;
    forever begin
      tick();
      if (hs_flag && src_q.size() > 0) void'(src_q.pop_front());
      ifc.i_data_valid = valid_en && (src_q.size() > 0) && ($urandom_range(0, 99) < valid_pct);
      ifc.i_data       = (src_q.size() > 0) ? src_q[0] : 8'h00;
    end
  end

  // monitor + scoreboard
  initial begin
    logic        prev_stb, prev_rst, prev_abort, prev_dir, ufl_ok;
    logic [3:0]  exp_nib;
    logic [7:0]  cur_byte;
    logic [15:0] crc_exp [4];
    int          n2, off, c;
    prev_stb = 0; prev_rst = 1; prev_abort = 0; prev_dir = 0;
    mon_j = 0; hs_flag = 0; cur_byte = 8'hFF;
    forever begin
      @(negedge clk);
      ufl_ok = 1'b0;
      if (ifc.o_done === 1'b1) done_cnt++;
      if (prev_stb && !prev_rst && !prev_abort) begin
        n2 = 2 * cur_n;
        if (prev_dir && !ifc.o_sd_data_dir) begin
          chk("frame_len", mon_j, P + 2 + n2 + 16);
          chk("end_done", ifc.o_done, 1);
          chk("end_idle_out", ifc.o_sd_data_out, 8'hFF);
          chk("end_busy", ifc.o_busy, 0);
        end else if (ifc.o_sd_data_dir) begin
          if (mon_j < P) begin
            exp_nib = 4'hF;
          end else if (mon_j == P) begin
            exp_nib = 4'h0;
          end else if (mon_j < P + 1 + n2) begin
            off = mon_j - P - 1;
            if (off % 2 == 0) begin
              ufl_ok = 1'b1;
              if (ifc.o_underflow) begin
                cur_byte = 8'hFF;
                ufl_cnt++;
              end else begin
                chk("byte_avail", exp_byte_q.size() > 0, 1);
                cur_byte = (exp_byte_q.size() > 0) ? exp_byte_q.pop_front() : 8'hFF;
              end
              exp_nib = cur_byte[7:4];
            end else begin
              exp_nib = cur_byte[3:0];
            end
            nib_hist.push_back(exp_nib);
          end else if (mon_j < P + 1 + n2 + 16) begin
            c = mon_j - (P + 1 + n2);
            if (c == 0) for (int k = 0; k < 4; k++) crc_exp[k] = crc_line(k);
            for (int k = 0; k < 4; k++) exp_nib[k] = crc_exp[k][15 - c];
          end else begin
            chk("frame_overrun", mon_j, P + 1 + n2 + 16);
            exp_nib = 4'hF;
          end
          chk("nibble", ifc.o_sd_data_out, {exp_nib, exp_nib});
          mon_j++;
          drv_cnt++;
        end
      end
      if (!ufl_ok) chk("ufl_spurious", ifc.o_underflow, 0);
      if (ifc.o_busy !== 1'b1) begin
        mon_j = 0;
        exp_byte_q.delete();
        nib_hist.delete();
      end
      hs_flag = (ifc.o_data_ready === 1'b1) && (ifc.i_data_valid === 1'b1) &&
                !rst && !ifc.i_abort;
      if (hs_flag) begin
        exp_byte_q.push_back(ifc.i_data);
        hs_cnt++;
      end
      prev_stb   = ifc.i_stb;
      prev_rst   = rst;
      prev_abort = ifc.i_abort;
      prev_dir   = ifc.o_sd_data_dir;
    end
  end

  task automatic load_block(input int n, input int pct, input bit zeros);
    src_q.delete();
    for (int i = 0; i < n; i++) src_q.push_back(zeros ? 8'h00 : 8'($urandom));
    hs_cnt = 0; ufl_cnt = 0; drv_cnt = 0;
    valid_pct = pct;
    cur_n = n;
  endtask

  task automatic start_block(input int n);
    ifc.i_block_size = BW'(n);
    ifc.i_start = 1'b1;
    tick();
    ifc.i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) tick();
    chk(name, done_cnt - d0, 1);
  endtask

  task automatic wait_j(input int target, input int budget, input string name);
    for (int i = 0; i < budget && mon_j < target; i++) tick();
    chk(name, mon_j >= target, 1);
  endtask

  initial begin
    int d0, n;
    rst = 1'b1;
    ifc.i_start = 1'b0; ifc.i_abort = 1'b0; ifc.i_block_size = '0;
    repeat (3) tick();
    chk("rst_dir", ifc.o_sd_data_dir, 0);
    chk("rst_dout", ifc.o_sd_data_out, 8'hFF);
    chk("rst_busy", ifc.o_busy, 0);
    chk("rst_done", ifc.o_done, 0);
    chk("rst_ufl", ifc.o_underflow, 0);
    chk("rst_ready", ifc.o_data_ready, 0);
    rst = 1'b0;
    tick();

    // 1: reset mid-DATA
    stb_div = 2; load_block(8, 100, 0); start_block(8);
    wait_j(P + 4, 200, "t1_reach_data");
    rst = 1'b1; tick();
    chk("t1_dir", ifc.o_sd_data_dir, 0);
    chk("t1_dout", ifc.o_sd_data_out, 8'hFF);
    chk("t1_busy", ifc.o_busy, 0);
    chk("t1_ready", ifc.o_data_ready, 0);
    rst = 1'b0; repeat (3) tick();
    $display("block t1 reset mid-data");

    // 2: four zero bytes, strobe every 2 clk
    stb_div = 2; load_block(4, 100, 1); d0 = done_cnt; start_block(4);
    wait_done(400, "t2_done");
    repeat (10) tick();
    chk("t2_strobes", drv_cnt, 27);
    chk("t2_ufl", ufl_cnt, 0);
    chk("t2_hs", hs_cnt, 4);
    chk("t2_done_once", done_cnt - d0, 1);
    $display("block t2 n=4 strobes=%0d", drv_cnt);

    // 3: 512 random bytes, strobe every clk
    stb_div = 1; load_block(512, 100, 0); start_block(512);
    wait_done(5000, "t3_done");
    repeat (4) tick();
    chk("t3_ufl", ufl_cnt, 0);
    chk("t3_hs", hs_cnt, 512);
    chk("t3_strobes", drv_cnt, P + 2 + 1024 + 16);
    $display("block t3 n=512 hs=%0d", hs_cnt);

    // 4: underflow on first slot
    stb_div = 4; valid_en = 1'b0; load_block(2, 100, 0); d0 = done_cnt; start_block(2);
    for (int i = 0; i < 200 && ufl_cnt == 0; i++) tick();
    valid_en = 1'b1;
    wait_done(400, "t4_done");
    repeat (6) tick();
    chk("t4_ufl", ufl_cnt, 1);
    chk("t4_hs", hs_cnt, 1);
    chk("t4_done_once", done_cnt - d0, 1);
    $display("block t4 n=2 ufl=%0d hs=%0d", ufl_cnt, hs_cnt);

    // 5: start while busy ignored, abort in CRC
    stb_div = 2; load_block(3, 100, 0); start_block(3);
    wait_j(P + 3, 100, "t5_reach_data");
    ifc.i_block_size = BW'(7); ifc.i_start = 1'b1; tick(); ifc.i_start = 1'b0;
    wait_j(P + 1 + 6 + 4, 200, "t5_reach_crc");
    ifc.i_abort = 1'b1; tick(); ifc.i_abort = 1'b0;
    chk("t5_dir", ifc.o_sd_data_dir, 0);
    chk("t5_dout", ifc.o_sd_data_out, 8'hFF);
    chk("t5_busy", ifc.o_busy, 0);
    d0 = done_cnt;
    repeat (40) tick();
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_still_idle", ifc.o_busy, 0);
    // abort and start together: start dropped
    ifc.i_block_size = BW'(4); ifc.i_start = 1'b1; ifc.i_abort = 1'b1; tick();
    ifc.i_start = 1'b0; ifc.i_abort = 1'b0; tick();
    chk("t5_abort_start_busy", ifc.o_busy, 0);
    $display("block t5 aborted");

    // 6: zero-size start ignored
    ifc.i_block_size = '0; ifc.i_start = 1'b1; tick(); ifc.i_start = 1'b0;
    chk("t6_busy", ifc.o_busy, 0);
    chk("t6_ready", ifc.o_data_ready, 0);
    repeat (5) tick();
    chk("t6_dir", ifc.o_sd_data_dir, 0);
    chk("t6_busy_later", ifc.o_busy, 0);
    $display("block t6 size0 ignored");

    // random blocks with gappy payload
    for (int b = 0; b < 6; b++) begin
      n = $urandom_range(1, 24);
      stb_div = $urandom_range(1, 4);
      load_block(n, $urandom_range(30, 100), 0);
      start_block(n);
      wait_done(3000, "rnd_done");
      repeat (4) tick();
      chk("rnd_slots", hs_cnt + ufl_cnt, n);
      $display("block rnd n=%0d stb_div=%0d hs=%0d ufl=%0d", n, stb_div, hs_cnt, ufl_cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
